// File: rtl/packet_transmitter.sv
// Packet transmitter: fetches 36-bit words from ZBT SRAM, frames them as
// {SYNC_WORD, address, data, CRC-16-CCITT} and shifts them out MSB first,
// one bit per bit_tick, with an idle gap between frames.
//
// Optional feature: define TX_RESEND_EN to honour resend requests from the
// receiving end (resume from a given address at the next gap exit).
//
// Ports:
//   clk                 system clock, rising edge
//   reset               synchronous, active-high
//   i_start             one-cycle pulse, start sending from address 0
//   i_last_address      final address to send (inclusive), sampled on start
//   i_zbt_data_in       ZBT read data
//   i_bit_tick          one-cycle strobe per optical bit period
//   i_resend_req        resend request pulse
//   i_resend_address    address to resume from, valid with i_resend_req
//   o_zbt_read_address  ZBT read address
//   o_serial_out        optical link bit
//   o_busy              high whenever not idle
//   o_done              one-cycle pulse after the final frame's gap
//   o_state             current FSM state (debug)
module packet_transmitter #(
    parameter int         ZBT_LATENCY = 2,
    parameter int         GAP_BITS    = 16,
    parameter logic [7:0] SYNC_WORD   = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [18:0] i_last_address,
    input  logic [35:0] i_zbt_data_in,
    input  logic        i_bit_tick,
    input  logic        i_resend_req,
    input  logic [18:0] i_resend_address,
    output logic [18:0] o_zbt_read_address,
    output logic        o_serial_out,
    output logic        o_busy,
    output logic        o_done,
    output logic [2:0]  o_state
);

    localparam int LW = (ZBT_LATENCY < 1) ? 1 : $clog2(ZBT_LATENCY + 1);
    localparam int GW = (GAP_BITS < 2) ? 1 : $clog2(GAP_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CRC   = 3'd2,
        S_SEND  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t      r_state;
    logic [18:0] r_cur_addr;
    logic [18:0] r_last_addr;
    logic [18:0] r_zbt_addr;
    logic [LW-1:0] r_lat_cnt;
    logic [35:0] r_data;
    logic [54:0] r_crc_sh;
    logic [15:0] r_crc;
    logic [5:0]  r_crc_cnt;
    logic [78:0] r_shift;
    logic [6:0]  r_bit_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic        r_serial;
    logic        r_done;

    logic        w_fb;
    logic [15:0] w_crc_next;
    logic [18:0] w_next_addr;
    logic        w_finish;

    // One CRC-16-CCITT step per clock over the packet header+data bits.
    assign w_fb       = r_crc[15] ^ r_crc_sh[54];
    assign w_crc_next = {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);

`ifdef TX_RESEND_EN
    logic        r_pend;
    logic [18:0] r_pend_addr;
    logic        w_rs_ok;

    // Out-of-range requests and requests while idle are dropped.
    assign w_rs_ok = i_resend_req && (r_state != S_IDLE) &&
                     (i_resend_address <= r_last_addr);

    // A request arriving on the exit cycle beats an older pending one.
    always_comb begin
        w_next_addr = r_cur_addr + 19'd1;
        w_finish    = (r_cur_addr == r_last_addr);
        if (w_rs_ok) begin
            w_next_addr = i_resend_address;
            w_finish    = 1'b0;
        end else if (r_pend) begin
            w_next_addr = r_pend_addr;
            w_finish    = 1'b0;
        end
    end
`else
    logic w_unused_resend;

    assign w_unused_resend = ^{i_resend_req, i_resend_address};
    assign w_next_addr     = r_cur_addr + 19'd1;
    assign w_finish        = (r_cur_addr == r_last_addr);
`endif

    always_ff @(posedge clk) begin
        r_done <= 1'b0;
        if (reset) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_last_addr <= '0;
            r_zbt_addr  <= '0;
            r_lat_cnt   <= '0;
            r_data      <= '0;
            r_crc_sh    <= '0;
            r_crc       <= '0;
            r_crc_cnt   <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_serial    <= 1'b0;
`ifdef TX_RESEND_EN
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
`endif
        end else begin
`ifdef TX_RESEND_EN
            if (w_rs_ok) begin
                r_pend      <= 1'b1;
                r_pend_addr <= i_resend_address;
            end
`endif
            case (r_state)
                S_IDLE: begin
                    r_serial <= 1'b0;
                    if (i_start) begin
                        r_cur_addr  <= '0;
                        r_last_addr <= i_last_address;
                        r_zbt_addr  <= '0;
                        r_lat_cnt   <= '0;
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_serial <= 1'b0;
                    // Data for the address shown in FETCH cycle 0 is
                    // valid in cycle ZBT_LATENCY.
                    if (r_lat_cnt == LW'(ZBT_LATENCY)) begin
                        r_data    <= i_zbt_data_in;
                        r_crc_sh  <= {r_cur_addr, i_zbt_data_in};
                        r_crc     <= 16'hFFFF;
                        r_crc_cnt <= '0;
                        r_state   <= S_CRC;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                S_CRC: begin
                    r_serial <= 1'b0;
                    r_crc    <= w_crc_next;
                    r_crc_sh <= {r_crc_sh[53:0], 1'b0};
                    if (r_crc_cnt == 6'd54) begin
                        r_shift   <= {SYNC_WORD, r_cur_addr, r_data,
                                      w_crc_next};
                        r_bit_cnt <= '0;
                        r_state   <= S_SEND;
                    end else begin
                        r_crc_cnt <= r_crc_cnt + 6'd1;
                    end
                end
                S_SEND: begin
                    if (i_bit_tick) begin
                        r_serial <= r_shift[78];
                        r_shift  <= {r_shift[77:0], 1'b0};
                        if (r_bit_cnt == 7'd78) begin
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 7'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (i_bit_tick) begin
                        r_serial <= 1'b0;
                        if (r_gap_cnt == GW'(GAP_BITS - 1)) begin
`ifdef TX_RESEND_EN
                            r_pend <= 1'b0;
`endif
                            if (w_finish) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_cur_addr <= w_next_addr;
                                r_zbt_addr <= w_next_addr;
                                r_lat_cnt  <= '0;
                                r_state    <= S_FETCH;
                            end
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_serial <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign o_zbt_read_address = r_zbt_addr;
    assign o_serial_out       = r_serial;
    assign o_busy             = (r_state != S_IDLE);
    assign o_done             = r_done;
    assign o_state            = r_state;

endmodule

// File: tb/tb_packet_transmitter.sv
// Self-checking bench for packet_transmitter: a frame-level model of the
// serial stream (sync, address, data, CRC, gap) checked every cycle.
module tb_packet_transmitter;

    localparam int GAP = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [18:0] i_last_address;
    logic [35:0] i_zbt_data_in;
    logic        i_bit_tick;
    logic        i_resend_req;
    logic [18:0] i_resend_address;
    logic [18:0] o_zbt_read_address;
    logic        o_serial_out;
    logic        o_busy;
    logic        o_done;
    logic [2:0]  o_state;

    packet_transmitter dut (
        .clk                (clk),
        .reset              (reset),
        .i_start            (i_start),
        .i_last_address     (i_last_address),
        .i_zbt_data_in      (i_zbt_data_in),
        .i_bit_tick         (i_bit_tick),
        .i_resend_req       (i_resend_req),
        .i_resend_address   (i_resend_address),
        .o_zbt_read_address (o_zbt_read_address),
        .o_serial_out       (o_serial_out),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_state            (o_state)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event not seen within budget", name);
    endtask

    // ZBT model: two-clock read latency from address to data.
    logic [35:0] mem [0:7];
    logic [18:0] zpipe0, zpipe1;
    always @(posedge clk) begin
        zpipe0 <= o_zbt_read_address;
        zpipe1 <= zpipe0;
    end
    assign i_zbt_data_in = mem[zpipe1[2:0]];

    function automatic logic [15:0] crc_bits(input logic [127:0] v,
                                             input int n);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[15] ^ v[i];
            c = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic logic [78:0] model_frame(input logic [18:0] a);
        logic [35:0] d;
        d = mem[a[2:0]];
        return {SYNC, a, d, crc_bits({73'b0, a, d}, 55)};
    endfunction

    // Bit tick generator: every 4th clock, optionally forced high in
    // FETCH/CRC or unconditionally.
    int   cyc = 0;
    logic tick_hold = 1'b0;
    logic tick_force = 1'b0;
    always @(posedge clk) begin
        #1;
        cyc++;
        i_bit_tick = tick_force ||
                     (tick_hold && (o_state == 3'd1 || o_state == 3'd2)) ||
                     (cyc % 4 == 0);
    end

    // Frame-level monitor.
    logic [18:0] exp_q[$];
    logic [78:0] got_q[$];
    int          m_mode = 0;
    int          m_bits = 0;
    int          m_gap = 0;
    logic [78:0] m_frame = '0;
    logic        m_last = 1'b0;
    logic        p_tick = 1'b0;
    logic        p_reset = 1'b1;
    logic        p_busy = 1'b0;
    logic        p_done = 1'b0;
    int          done_cnt = 0;

    task automatic frame_done();
        logic [18:0] a;
        got_q.push_back(m_frame);
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL extra_frame: got addr %0h, none expected",
                     m_frame[70:52]);
        end else begin
            a = exp_q.pop_front();
            chk("frame_addr", {109'b0, m_frame[70:52]}, {109'b0, a});
            chk("frame_bits", {49'b0, m_frame}, {49'b0, model_frame(a)});
        end
    endtask

    always @(negedge clk) begin
        if (p_reset) begin
            m_mode = 0;
            m_bits = 0;
            m_gap = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (p_tick && o_serial_out) begin
                        m_mode = 1;
                        m_frame = 79'd1;
                        m_bits = 1;
                        m_last = 1'b1;
                    end else if (!p_tick) begin
                        chk("idle_zero", {127'b0, o_serial_out}, 128'd0);
                    end
                end
                1: begin
                    if (p_tick) begin
                        m_frame = {m_frame[77:0], o_serial_out};
                        m_last = o_serial_out;
                        m_bits++;
                        if (m_bits == 79) begin
                            frame_done();
                            m_mode = 2;
                            m_gap = 0;
                        end
                    end else begin
                        chk("bit_hold", {127'b0, o_serial_out},
                            {127'b0, m_last});
                    end
                end
                default: begin
                    if (p_tick) begin
                        chk("gap_zero", {127'b0, o_serial_out}, 128'd0);
                        m_last = 1'b0;
                        m_gap++;
                        if (m_gap == GAP) m_mode = 0;
                    end else begin
                        chk("gap_hold", {127'b0, o_serial_out},
                            {127'b0, m_last});
                    end
                end
            endcase
            if (o_done) begin
                done_cnt++;
                chk("done_after_gap", 128'(m_mode), 128'd0);
                chk("done_queue_empty", 128'(exp_q.size()), 128'd0);
                chk("done_busy_low", {127'b0, o_busy}, 128'd0);
            end
            if (p_done) chk("done_one_cycle", {127'b0, o_done}, 128'd0);
            if (p_busy && !o_busy)
                chk("busy_falls_with_done", {127'b0, o_done}, 128'd1);
        end
        p_tick = i_bit_tick;
        p_reset = reset;
        p_busy = o_busy;
        p_done = o_done;
    end

    task automatic do_start(input logic [18:0] last);
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_last_address = last;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic run(input logic [18:0] last, input int budget);
        int d0;
        int t;
        d0 = done_cnt;
        t = 0;
        do_start(last);
        while (done_cnt == d0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) begin
            fail_now("run_done");
        end else begin
            repeat (60) @(negedge clk);
            chk("single_done", 128'(done_cnt - d0), 128'd1);
            chk("idle_after_run", {127'b0, o_busy}, 128'd0);
            chk("queue_drained", 128'(exp_q.size()), 128'd0);
        end
    endtask

    task automatic resend_at3(input logic [18:0] ra);
        int t;
        t = 0;
        while (!(o_state == 3'd3 && o_zbt_read_address == 19'd3) &&
               t < 6000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 6000) begin
            fail_now("resend_window");
        end else begin
            i_resend_req = 1'b1;
            i_resend_address = ra;
            @(posedge clk);
            #1;
            i_resend_req = 1'b0;
        end
    endtask

    initial begin
        logic [18:0] seq[$];
        int t;
        reset = 1'b1;
        i_start = 1'b0;
        i_last_address = '0;
        i_resend_req = 1'b0;
        i_resend_address = '0;
        i_bit_tick = 1'b0;
        mem[0] = 36'h1_2345_6789;
        mem[1] = 36'hA_BCDE_F012;
        mem[2] = 36'h0_0000_0001;
        mem[3] = 36'h3_3333_3333;
        mem[4] = 36'hF_0F0F_0F0F;
        mem[5] = 36'h5_5555_5555;
        mem[6] = 36'h6_6666_6666;
        mem[7] = 36'h7_7777_7777;

        // Pin the CRC model against known values.
        chk("crc_check_string",
            {112'b0, crc_bits({56'b0, 72'h313233343536373839}, 72)},
            {112'b0, 16'h29B1});
        chk("crc_empty", {112'b0, crc_bits(128'd0, 0)}, {112'b0, 16'hFFFF});
        chk("crc_one_zero_bit", {112'b0, crc_bits(128'd0, 1)},
            {112'b0, 16'hEFDF});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_serial", {127'b0, o_serial_out}, 128'd0);
        chk("rst_busy", {127'b0, o_busy}, 128'd0);
        chk("rst_done", {127'b0, o_done}, 128'd0);
        chk("rst_state", {125'b0, o_state}, 128'd0);
        chk("rst_zbt_addr", {109'b0, o_zbt_read_address}, 128'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Three frames, addresses 0..2.
        exp_q = {19'd0, 19'd1, 19'd2};
        got_q.delete();
        run(19'd2, 8000);
        if (got_q.size() == 3) begin
            chk("f0_sync", {120'b0, got_q[0][78:71]}, {120'b0, 8'hA5});
            chk("f0_addr", {109'b0, got_q[0][70:52]}, 128'd0);
            chk("f0_data", {92'b0, got_q[0][51:16]},
                {92'b0, 36'h1_2345_6789});
            chk("f2_addr", {109'b0, got_q[2][70:52]}, 128'd2);
            chk("f2_data", {92'b0, got_q[2][51:16]}, 128'd1);
        end else begin
            chk("three_frames", 128'(got_q.size()), 128'd3);
        end

        // Single frame.
        exp_q = {19'd0};
        got_q.delete();
        run(19'd0, 4000);
        chk("one_frame", 128'(got_q.size()), 128'd1);

        // Resend to address 1 during frame 3's transmission.
`ifdef TX_RESEND_EN
        seq = {19'd0, 19'd1, 19'd2, 19'd3, 19'd1, 19'd2, 19'd3, 19'd4,
               19'd5};
`else
        seq = {19'd0, 19'd1, 19'd2, 19'd3, 19'd4, 19'd5};
`endif
        exp_q = seq;
        got_q.delete();
        fork
            run(19'd5, 8000);
            resend_at3(19'd1);
        join
        chk("resend_frames", 128'(got_q.size()), 128'(seq.size()));

        // Out-of-range resend is ignored.
        exp_q = {19'd0, 19'd1, 19'd2, 19'd3, 19'd4, 19'd5};
        got_q.delete();
        fork
            run(19'd5, 8000);
            resend_at3(19'd9);
        join
        chk("bad_resend_frames", 128'(got_q.size()), 128'd6);

        // Start while busy and ticks held high in FETCH/CRC are ignored.
        tick_hold = 1'b1;
        exp_q = {19'd0, 19'd1, 19'd2};
        got_q.delete();
        fork
            run(19'd2, 8000);
            begin
                repeat (100) @(posedge clk);
                #1;
                i_start = 1'b1;
                i_last_address = 19'd6;
                @(posedge clk);
                #1;
                i_start = 1'b0;
                repeat (500) @(posedge clk);
                #1;
                i_start = 1'b1;
                @(posedge clk);
                #1;
                i_start = 1'b0;
            end
        join
        tick_hold = 1'b0;
        chk("busy_start_frames", 128'(got_q.size()), 128'd3);

        // Reset mid-frame, with start/resend/tick asserted alongside.
        exp_q = {19'd0, 19'd1, 19'd2, 19'd3};
        got_q.delete();
        do_start(19'd3);
        t = 0;
        while (!(m_mode == 1 && m_bits == 40 && got_q.size() == 0) &&
               t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) fail_now("reach_bit40");
        @(posedge clk);
        #1;
        reset = 1'b1;
        i_start = 1'b1;
        i_resend_req = 1'b1;
        i_resend_address = 19'd0;
        tick_force = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_serial", {127'b0, o_serial_out}, 128'd0);
        chk("midrst_busy", {127'b0, o_busy}, 128'd0);
        chk("midrst_state", {125'b0, o_state}, 128'd0);
        chk("midrst_done", {127'b0, o_done}, 128'd0);
        chk("midrst_zbt", {109'b0, o_zbt_read_address}, 128'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        i_start = 1'b0;
        i_resend_req = 1'b0;
        tick_force = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_stays_idle", {127'b0, o_busy}, 128'd0);
        got_q.delete();
        exp_q = {19'd0};
        run(19'd0, 4000);
        chk("restart_frames", 128'(got_q.size()), 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/packet_transmitter.md
PACKET_TRANSMITTER -- requirements
Module: packet_transmitter

Interface
REQ-001 SHALL have parameter ZBT_LATENCY, default 2, clocks from zbt_read_address to valid zbt_data_in.
REQ-002 SHALL have parameter GAP_BITS, default 16, idle bit periods between frames.
REQ-003 SHALL have parameter SYNC_WORD, default 8'hA5, frame preamble.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 start  input  1  one-cycle pulse; begins transmission from address 0.
REQ-007 last_address  input  19  final ZBT address to send, inclusive; sampled on accepted start.
REQ-008 zbt_data_in  input  36  ZBT read data.
REQ-009 bit_tick  input  1  one-cycle strobe per optical bit period.
REQ-010 resend_req  input  1  one-cycle pulse from the receiving end.
REQ-011 resend_address  input  19  address to resume from; valid with resend_req.
REQ-012 zbt_read_address  output  19  ZBT read address.
REQ-013 serial_out  output  1  optical link bit, MSB first.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 done  output  1  one-cycle pulse after final frame's gap completes.
REQ-016 state  output  3  current FSM state, for debug.

Function
REQ-017 SHALL implement states IDLE=0, FETCH=1, CRC=2, SEND=3, GAP=4.
- IDLE->FETCH on start; start while busy SHALL be ignored.
REQ-018 FETCH SHALL drive zbt_read_address = cur_addr, wait ZBT_LATENCY clocks, then capture zbt_data_in and go to CRC.
REQ-019 Packet SHALL be 71 bits:
- [70:52] = cur_addr
- [51:16] = data
- [15:0] = CRC
REQ-020 CRC SHALL be CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR) over bits [70:16] MSB first, computed bit-serially at one bit per clk, 55 clocks, then CRC->SEND.
REQ-021 SEND SHALL shift out SYNC_WORD (8 bits) then the 71 packet bits, MSB first, one bit per bit_tick; serial_out SHALL hold each bit until the next bit_tick. The first bit SHALL drive at the first bit_tick after entering SEND.
REQ-022 After 79 bits, SEND->GAP; serial_out SHALL be 0 for GAP_BITS bit_ticks.
REQ-023 GAP exit:
- if cur_addr == last_address and no resend pending: pulse done, go to IDLE.
- otherwise: set cur_addr to next address (REQ-024), go to FETCH.
REQ-024 Next address SHALL be cur_addr+1 (19-bit). No wrap SHALL occur, because cur_addr never exceeds last_address.
REQ-025 bit_tick outside SEND/GAP SHALL be ignored; serial_out SHALL be 0 in IDLE, FETCH and CRC.
REQ-026 last_address = 0 SHALL send exactly one frame (address 0).
REQ-027 zbt_read_address SHALL hold its last value outside FETCH.

Reset
REQ-028 reset SHALL force the following on the next clk edge, aborting any frame mid-bit:
- state = IDLE
- serial_out = 0, busy = 0, done = 0
- zbt_read_address = 0
- cur_addr = 0
- shift register and CRC cleared
- resend pending flag cleared
REQ-029 reset SHALL take priority over start, resend_req and bit_tick in the same cycle.

Configuration
REQ-030 Macro TX_RESEND_EN SHALL control resend handling.
- Defined: resend_req while busy SHALL latch resend_address into a pending register. Pending takes effect at the next GAP exit, when cur_addr SHALL be set to the pending address instead of cur_addr+1, and the pending flag SHALL clear. If resend_req and GAP exit coincide, the new request SHALL be applied at that exit. A later request SHALL overwrite an earlier pending one. resend_address > last_address SHALL be ignored. resend_req in IDLE SHALL be ignored.
- Undefined: resend_req and resend_address SHALL be ignored entirely; no pending register is built.

Verification
REQ-031 last_address=2, zbt data 36'h1_2345_6789 / 36'hA_BCDE_F012 / 36'h0_0000_0001, bit_tick every 4 clk -> 3 frames, each starting 8'hA5, with addresses 0,1,2 and correct CRC; done pulses once; busy falls with done.
REQ-032 last_address=0 -> exactly one 79-bit frame, then 16 zero bits, then done.
REQ-033 TX_RESEND_EN defined, last_address=5, resend_req with resend_address=1 during frame 3's SEND -> frame order 0,1,2,3,1,2,3,4,5.
REQ-034 TX_RESEND_EN defined, resend_address=9 with last_address=5 -> ignored, order 0..5. TX_RESEND_EN undefined, same stimulus as REQ-033 -> order 0..5.
REQ-035 reset asserted at bit 40 of frame 1 -> next clk: serial_out=0, busy=0, state=0; a subsequent start restarts at address 0.
REQ-036 start pulsed while busy, and bit_tick held high during FETCH/CRC -> no change in frame sequence or timing.
